// File: rtl/axi_bridge_pkg.sv
// Shared AXI4 channel payloads, burst encodings and FSM states for the burst bridge.
// Channel widths are fixed here; the bridge parameters must match them.
package axi_bridge_pkg;

    localparam int AXI_ADDR_W = 32;
    localparam int AXI_DATA_W = 32;
    localparam int AXI_ID_W   = 4;
    localparam int AXI_STRB_W = AXI_DATA_W / 8;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    typedef struct packed {
        logic [AXI_ID_W-1:0]   id;
        logic [AXI_ADDR_W-1:0] addr;
        logic [7:0]            len;
        logic [2:0]            size;
        logic [1:0]            burst;
    } axi_ar_t;

    typedef struct packed {
        logic [AXI_ID_W-1:0]   id;
        logic [AXI_ADDR_W-1:0] addr;
        logic [7:0]            len;
        logic [2:0]            size;
        logic [1:0]            burst;
    } axi_aw_t;

    typedef struct packed {
        logic [AXI_DATA_W-1:0] data;
        logic                  last;
        logic [1:0]            resp;
    } axi_r_t;

    typedef struct packed {
        logic [AXI_DATA_W-1:0] data;
        logic [AXI_STRB_W-1:0] strb;
        logic                  last;
    } axi_w_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_ADDR,
        R_DATA
    } rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_ADDR,
        W_DATA,
        W_RESP
    } wr_state_e;

endpackage

// File: rtl/axi_beat_counter.sv
// Burst beat counter: cleared when a burst is accepted, bumped per data handshake.
// is_last flags the beat whose index equals the latched AXI len.
module axi_beat_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       inc,
    input  logic [7:0] len,
    output logic       is_last
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = 8'd0;
        end else if (inc) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign is_last = (cnt_q == len);

endmodule

// File: rtl/axi_burst_bridge.sv
// Cache refill / write-back burst bridge onto AXI4 with independent read and write FSMs.
// Define AXI_BRIDGE_RAW_CHECK_EN to hold off reads that hit the line of an in-flight write.
module axi_burst_bridge
    import axi_bridge_pkg::*;
#(
    parameter int ADDR_W     = AXI_ADDR_W,
    parameter int DATA_W     = AXI_DATA_W,
    parameter int ID_W       = AXI_ID_W,
    parameter int RD_ID      = 0,
    parameter int WR_ID      = 1,
    parameter int LINE_BYTES = 32,
    localparam int STRB_W    = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_len,
    input  logic [2:0]        rd_size,
    output logic              rd_addr_ok,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              rd_last,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_len,
    input  logic [2:0]        wr_size,
    output logic              wr_addr_ok,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [STRB_W-1:0] wr_strb,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic              wr_done,
    output axi_ar_t           ar_o,
    output logic              arvalid,
    input  logic              arready,
    input  axi_r_t            r_i,
    input  logic              rvalid,
    output logic              rready,
    output axi_aw_t           aw_o,
    output logic              awvalid,
    input  logic              awready,
    output axi_w_t            w_o,
    output logic              wvalid,
    input  logic              wready,
    input  logic              bvalid,
    output logic              bready
);

    localparam int LINE_LSB = $clog2(LINE_BYTES);

    rd_state_e r_state_q, r_state_d;
    wr_state_e w_state_q, w_state_d;
    axi_ar_t   ar_q, ar_d;
    axi_aw_t   aw_q, aw_d;
    logic      wr_done_q, wr_done_d;
    logic      rd_clr, rd_inc, rd_is_last;
    logic      wr_clr, wr_inc, wr_is_last;
    logic      same_line, raw_hold;

    assign same_line = rd_addr[ADDR_W-1:LINE_LSB] == aw_q.addr[ADDR_W-1:LINE_LSB];

`ifdef AXI_BRIDGE_RAW_CHECK_EN
    // wr_done_q extends the hold so the read lands strictly after the done pulse
    assign raw_hold = ((w_state_q != W_IDLE) || wr_done_q) && same_line;
`else
    assign raw_hold = 1'b0;
`endif

    always_comb begin
        r_state_d  = r_state_q;
        ar_d       = ar_q;
        rd_addr_ok = 1'b0;
        rd_clr     = 1'b0;
        rd_inc     = 1'b0;
        unique case (r_state_q)
            R_IDLE: if (rd_req && !raw_hold) begin
                rd_addr_ok = 1'b1;
                rd_clr     = 1'b1;
                ar_d.id    = ID_W'(RD_ID);
                ar_d.addr  = rd_addr;
                ar_d.len   = rd_len;
                ar_d.size  = rd_size;
                ar_d.burst = BURST_INCR;
                r_state_d  = R_ADDR;
            end
            R_ADDR: if (arready) r_state_d = R_DATA;
            R_DATA: if (rvalid) begin
                rd_inc = 1'b1;
                if (rd_is_last) r_state_d = R_IDLE;
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        w_state_d  = w_state_q;
        aw_d       = aw_q;
        wr_addr_ok = 1'b0;
        wr_done_d  = 1'b0;
        wr_clr     = 1'b0;
        wr_inc     = 1'b0;
        unique case (w_state_q)
            W_IDLE: if (wr_req) begin
                wr_addr_ok = 1'b1;
                wr_clr     = 1'b1;
                aw_d.id    = ID_W'(WR_ID);
                aw_d.addr  = wr_addr;
                aw_d.len   = wr_len;
                aw_d.size  = wr_size;
                aw_d.burst = BURST_INCR;
                w_state_d  = W_ADDR;
            end
            W_ADDR: if (awready) w_state_d = W_DATA;
            W_DATA: if (wr_valid && wready) begin
                wr_inc = 1'b1;
                if (wr_is_last) w_state_d = W_RESP;
            end
            W_RESP: if (bvalid) begin
                wr_done_d = 1'b1;
                w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= R_IDLE;
            w_state_q <= W_IDLE;
            ar_q      <= '0;
            aw_q      <= '0;
            wr_done_q <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            w_state_q <= w_state_d;
            ar_q      <= ar_d;
            aw_q      <= aw_d;
            wr_done_q <= wr_done_d;
        end
    end

    axi_beat_counter u_rd_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr     (rd_clr),
        .inc     (rd_inc),
        .len     (ar_q.len),
        .is_last (rd_is_last)
    );

    axi_beat_counter u_wr_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr     (wr_clr),
        .inc     (wr_inc),
        .len     (aw_q.len),
        .is_last (wr_is_last)
    );

    assign ar_o     = ar_q;
    assign arvalid  = (r_state_q == R_ADDR);
    assign rready   = (r_state_q == R_DATA);
    assign rd_valid = rready && rvalid;
    assign rd_data  = r_i.data;
    // Beat count, not r_i.last, ends the burst
    assign rd_last  = rd_valid && rd_is_last;

    assign aw_o     = aw_q;
    assign awvalid  = (w_state_q == W_ADDR);
    assign wvalid   = (w_state_q == W_DATA) && wr_valid;
    assign wr_ready = (w_state_q == W_DATA) && wready;
    assign w_o.data = wr_data;
    assign w_o.strb = wr_strb;
    assign w_o.last = wr_is_last;
    assign bready   = (w_state_q == W_RESP);
    assign wr_done  = wr_done_q;

    logic unused_sig;
    assign unused_sig = ^{same_line, r_i.last, r_i.resp};

endmodule
